// File: rtl/wb_pkg.sv
// Shared constants, types and skid-buffer state encoding for the writeback stage.
package wb_pkg;
    localparam int NREGS = 16;
    localparam int XLEN  = 32;
    localparam int AW    = $clog2(NREGS);

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] word_t;

    typedef enum logic {
        SKID_EMPTY = 1'b0,
        SKID_FULL  = 1'b1
    } skid_state_t;
endpackage

// File: rtl/stage_writeback_scoreboard.sv
// Pending-load scoreboard: one busy bit per register plus a sticky double-issue flag.
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  reg_addr_t        set_addr,
    input  logic             clr_en,
    input  reg_addr_t        clr_addr,
    output logic [NREGS-1:0] busy,
    output logic             err_double
);
    logic [NREGS-1:0] busy_nxt;
    logic             dbl;

    // Clear is applied first so that a same-cycle issue to the same register wins.
    always_comb begin
        busy_nxt = busy;
        if (clr_en) busy_nxt[clr_addr] = 1'b0;
        if (set_en) busy_nxt[set_addr] = 1'b1;
    end

    assign dbl = set_en && busy[set_addr] && !(clr_en && (clr_addr == set_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= '0;
            err_double <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (dbl) err_double <= 1'b1;
        end
    end
endmodule

// File: rtl/stage_writeback.sv
// Writeback stage: merges load responses (priority) and execute results through a
// one-entry skid buffer into a registered register-file write port.
// Optional macro WB_FORWARD_EN adds fwd_* outputs and a combinational busy_next view.
module stage_writeback
    import wb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  reg_addr_t        ex_addr,
    input  word_t            ex_data,
    input  logic             ld_issue_valid,
    input  reg_addr_t        ld_issue_addr,
    input  logic             ld_resp_valid,
    output logic             ld_resp_ready,
    input  reg_addr_t        ld_resp_addr,
    input  word_t            ld_resp_data,
    output logic             wr_en,
    output reg_addr_t        wr_addr,
    output word_t            wr_data,
    output logic [NREGS-1:0] busy,
    output logic             err_double
`ifdef WB_FORWARD_EN
    ,
    output logic             fwd_valid,
    output reg_addr_t        fwd_addr,
    output word_t            fwd_data,
    output logic [NREGS-1:0] busy_next
`endif
);
    // Handshakes: a transfer happens on a cycle where valid && ready at the rising edge.
    skid_state_t state, state_next;
    reg_addr_t   skid_addr;
    word_t       skid_data;
    logic        ex_acc;
    logic        ld_acc;
    logic        sel_valid;
    reg_addr_t   sel_addr;
    word_t       sel_data;
    logic        skid_load;

    // ex_ready depends only on registered state, never on this cycle's valids.
    assign ex_ready      = !rst && (state == SKID_EMPTY);
    assign ld_resp_ready = !rst;
    assign ex_acc        = ex_valid && ex_ready;
    assign ld_acc        = ld_resp_valid && ld_resp_ready;

    always_comb begin
        state_next = state;
        sel_valid  = 1'b0;
        sel_addr   = '0;
        sel_data   = '0;
        skid_load  = 1'b0;
        if (ld_acc) begin
            sel_valid = 1'b1;
            sel_addr  = ld_resp_addr;
            sel_data  = ld_resp_data;
            if (ex_acc) begin
                skid_load  = 1'b1;
                state_next = SKID_FULL;
            end
        end else if (state == SKID_FULL) begin
            sel_valid  = 1'b1;
            sel_addr   = skid_addr;
            sel_data   = skid_data;
            state_next = SKID_EMPTY;
        end else if (ex_acc) begin
            sel_valid = 1'b1;
            sel_addr  = ex_addr;
            sel_data  = ex_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SKID_EMPTY;
            skid_addr <= '0;
            skid_data <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            state <= state_next;
            if (skid_load) begin
                skid_addr <= ex_addr;
                skid_data <= ex_data;
            end
            // r0 transfers complete the handshake but never strobe the register file.
            wr_en <= sel_valid && (sel_addr != '0);
            if (sel_valid) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end
    end

    wb_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en     (ld_issue_valid && (ld_issue_addr != '0)),
        .set_addr   (ld_issue_addr),
        .clr_en     (ld_acc),
        .clr_addr   (ld_resp_addr),
        .busy       (busy),
        .err_double (err_double)
    );

`ifdef WB_FORWARD_EN
    assign fwd_valid = wr_en;
    assign fwd_addr  = wr_addr;
    assign fwd_data  = wr_data;
    always_comb begin
        busy_next = busy;
        if (ld_acc) busy_next[ld_resp_addr] = 1'b0;
    end
`endif
endmodule

// File: tb/tb_stage_writeback.sv
// Self-checking bench for stage_writeback against a queue-based reference model.
module tb_stage_writeback;
    import wb_pkg::*;

    logic             clk;
    logic             rst;
    logic             ex_valid;
    logic             ex_ready;
    reg_addr_t        ex_addr;
    word_t            ex_data;
    logic             ld_issue_valid;
    reg_addr_t        ld_issue_addr;
    logic             ld_resp_valid;
    logic             ld_resp_ready;
    reg_addr_t        ld_resp_addr;
    word_t            ld_resp_data;
    logic             wr_en;
    reg_addr_t        wr_addr;
    word_t            wr_data;
    logic [NREGS-1:0] busy;
    logic             err_double;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending ALU results waiting behind loads, expected writes,
    // per-register pending flags.
    logic [AW+XLEN-1:0] skid_q[$];
    logic [AW+XLEN-1:0] exp_q[$];
    logic               m_busy[NREGS];
    logic               m_err;
    logic               m_wr_en;

    stage_writeback dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_addr        (ex_addr),
        .ex_data        (ex_data),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_addr  (ld_issue_addr),
        .ld_resp_valid  (ld_resp_valid),
        .ld_resp_ready  (ld_resp_ready),
        .ld_resp_addr   (ld_resp_addr),
        .ld_resp_data   (ld_resp_data),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .busy           (busy),
        .err_double     (err_double)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NREGS-1:0] model_busy_vec();
        logic [NREGS-1:0] v;
        for (int i = 0; i < NREGS; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        skid_q.delete();
        exp_q.delete();
        for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
        m_err   = 1'b0;
        m_wr_en = 1'b0;
    endtask

    task automatic drive_idle();
        ex_valid       = 1'b0;
        ex_addr        = '0;
        ex_data        = '0;
        ld_issue_valid = 1'b0;
        ld_issue_addr  = '0;
        ld_resp_valid  = 1'b0;
        ld_resp_addr   = '0;
        ld_resp_data   = '0;
    endtask

    // One clock: check readiness, drive inputs, advance the model, check the result.
    task automatic step(input logic ev, input reg_addr_t ea, input word_t ed,
                        input logic iv, input reg_addr_t ia,
                        input logic rv, input reg_addr_t ra, input word_t rd);
        logic               exp_ready;
        logic               have_wr;
        logic [AW+XLEN-1:0] wr_item;
        logic [AW+XLEN-1:0] got;
        exp_ready = (skid_q.size() == 0);
        n_checks++;
        if (ex_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL ex_ready: got %b expected %b at %0t", ex_ready, exp_ready, $time);
        end
        ex_valid = ev; ex_addr = ea; ex_data = ed;
        ld_issue_valid = iv; ld_issue_addr = ia;
        ld_resp_valid = rv; ld_resp_addr = ra; ld_resp_data = rd;

        have_wr = 1'b0;
        wr_item = '0;
        if (rv) begin
            have_wr = 1'b1;
            wr_item = {ra, rd};
            if (ev && exp_ready) skid_q.push_back({ea, ed});
        end else if (skid_q.size() != 0) begin
            have_wr = 1'b1;
            wr_item = skid_q.pop_front();
        end else if (ev) begin
            have_wr = 1'b1;
            wr_item = {ea, ed};
        end
        m_wr_en = have_wr && (wr_item[AW+XLEN-1:XLEN] != '0);
        if (m_wr_en) exp_q.push_back(wr_item);

        if (iv && ia != '0 && m_busy[ia] && !(rv && ra == ia)) m_err = 1'b1;
        if (rv) m_busy[ra] = 1'b0;
        if (iv && ia != '0) m_busy[ia] = 1'b1;

        @(posedge clk);
        #1;
        n_checks++;
        if (wr_en !== m_wr_en) begin
            n_fail++;
            $display("FAIL wr_en: got %b expected %b at %0t", wr_en, m_wr_en, $time);
        end
        if (m_wr_en) begin
            got = {wr_addr, wr_data};
            wr_item = exp_q.pop_front();
            n_checks++;
            if (got !== wr_item) begin
                n_fail++;
                $display("FAIL wr_addr/wr_data: got %h/%h expected %h/%h at %0t",
                         wr_addr, wr_data, wr_item[AW+XLEN-1:XLEN], wr_item[XLEN-1:0], $time);
            end
        end
        n_checks++;
        if (busy !== model_busy_vec()) begin
            n_fail++;
            $display("FAIL busy: got %h expected %h at %0t", busy, model_busy_vec(), $time);
        end
        n_checks++;
        if (err_double !== m_err) begin
            n_fail++;
            $display("FAIL err_double: got %b expected %b at %0t", err_double, m_err, $time);
        end
        drive_idle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic check_all_zero(input string tag);
        n_checks++;
        if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || busy !== '0 ||
            err_double !== 1'b0 || ex_ready !== 1'b0 || ld_resp_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got wr_en=%b wr_addr=%h wr_data=%h busy=%h err=%b ex_ready=%b ld_resp_ready=%b expected all zero",
                     tag, wr_en, wr_addr, wr_data, busy, err_double, ex_ready, ld_resp_ready);
        end
    endtask

    task automatic check_ready_after_release(input string tag);
        n_checks++;
        if (ex_ready !== 1'b1 || ld_resp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got ex_ready=%b ld_resp_ready=%b expected 1/1", tag, ex_ready, ld_resp_ready);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        #2 rst = 1'b0;
        #1;
        check_ready_after_release("reset_release");
        @(posedge clk);
        #1;
    endtask

    task automatic test_alu_write();
        step(1'b1, 4'd3, 32'h12345678, 1'b0, '0, 1'b0, '0, '0);
        idle(1);
    endtask

    task automatic test_load_scoreboard();
        step(1'b0, '0, '0, 1'b1, 4'd5, 1'b0, '0, '0);
        idle(3);
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, 4'd5, 32'hDEADBEEF);
        idle(1);
    endtask

    task automatic test_collision();
        step(1'b1, 4'd2, 32'h1, 1'b0, '0, 1'b1, 4'd7, 32'h2);
        idle(2);
    endtask

    task automatic test_back_to_back();
        step(1'b1, 4'd9, 32'hA5A5_0009, 1'b0, '0, 1'b1, 4'd10, 32'h0000_0010);
        for (int i = 0; i < 3; i++)
            step(1'b1, 4'd11, 32'hBAD0_0000 + i, 1'b0, '0, 1'b1, 4'd12 + 4'(i), 32'h100 + i);
        idle(2);
    endtask

    task automatic test_err_and_r0();
        step(1'b0, '0, '0, 1'b1, 4'd4, 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b1, 4'd4, 1'b0, '0, '0);
        idle(2);
        step(1'b0, '0, '0, 1'b1, 4'd0, 1'b0, '0, '0);
        step(1'b1, 4'd0, 32'hFFFF_FFFF, 1'b0, '0, 1'b0, '0, '0);
        idle(1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), word_t'($urandom),
                 $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), word_t'($urandom));
        idle(2);
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        model_reset();
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, '0, '0, 1'b1, 4'd4, 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b1, 4'd5, 1'b0, '0, '0);
        step(1'b1, 4'd6, 32'h6666_6666, 1'b0, '0, 1'b1, 4'd9, 32'h9999_9999);
        rst = 1'b1;
        #1;
        check_all_zero("reset_async");
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_ready_after_release("reset_mid_release");
        @(posedge clk);
        #1;
        idle(3);
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        model_reset();
        test_reset();
        test_alu_write();
        test_load_scoreboard();
        test_collision();
        test_back_to_back();
        test_err_and_r0();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stage_writeback.md
Name: stage_writeback

Overview:
- Write-side counterpart of the decode stage's register-file reads. Owns the single register-file write port.
- Merges ALU/execute results and load responses into one registered write stream.
- Keeps a per-register pending-load scoreboard so decode can stall on operands that are still in flight.
- Sits between the execute/memory stages and register_file.

Parameters:
- NREGS, 16, number of architectural registers; address width is clog2(NREGS) = 4.
- XLEN, 32, data word width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- ex_valid  in  1  execute result offered
- ex_ready  out  1  execute result accepted this cycle when ex_valid && ex_ready
- ex_addr  in  4  destination register of the execute result
- ex_data  in  XLEN  execute result value
- ld_issue_valid  in  1  decode issued a load this cycle
- ld_issue_addr  in  4  load destination register
- ld_resp_valid  in  1  memory returns load data
- ld_resp_ready  out  1  load response accepted
- ld_resp_addr  in  4  load destination register
- ld_resp_data  in  XLEN  load data
- wr_en  out  1  register-file write strobe
- wr_addr  out  4  register-file write address
- wr_data  out  XLEN  register-file write data
- busy  out  NREGS  scoreboard; bit i = load pending for register i
- err_double  out  1  sticky protocol-error flag

Behaviour:
- Reset (async, active-high): wr_en=0, wr_addr=0, wr_data=0, busy=0, err_double=0, skid buffer empty; ex_ready=1 and ld_resp_ready=1 once rst falls.
- Write port is registered: a transfer accepted in cycle N produces wr_en=1 with that addr/data in cycle N+1, for exactly one cycle per transfer.
- Priority: the load response always wins. ld_resp_ready is constantly 1 outside reset.
- ALU path uses a one-entry skid buffer:
  - If ex is accepted in the same cycle as a load response, the ex result is stored in the skid buffer.
  - A buffered entry writes on the next cycle with no load response, before any new ex result. Order is preserved.
  - ex_ready = !skid_full. It is registered, so there is no combinational path from ex_valid or ld_resp_valid to ex_ready.
- Skid full and ld_resp_valid: the load writes; the buffer keeps holding and ex_ready stays 0.
- Skid full and no load: the buffer drains; ex_ready returns to 1 the following cycle.
- Writes to address 0 are accepted on the handshake but produce wr_en=0. r0 is never written.
- Scoreboard:
  - ld_issue_valid with addr != 0 sets busy[addr] at the clock edge.
  - An accepted load response clears busy[ld_resp_addr] at the same edge its write is registered. Busy therefore drops in the same cycle wr_en appears, and decode sees the data next cycle through the register file.
  - Issue and response to the same register in the same cycle: set wins; busy stays 1.
  - Issue to a register already busy with no simultaneous clear: err_double is set (sticky until reset). The busy bit stays 1.
- Execute results to a busy register are written normally. Avoiding WAW is decode's responsibility.
- No internal FSM beyond the skid-buffer states EMPTY and FULL:
  - EMPTY→FULL on ex accept while ld_resp_valid.
  - FULL→EMPTY on a cycle with no ld_resp_valid.
  - FULL→FULL otherwise.
- Reset mid-operation discards the skid contents and all pending-load state.

Optional Feature:
- Macro WB_FORWARD_EN.
- Defined: adds outputs fwd_valid, fwd_addr[3:0], fwd_data[XLEN-1:0], equal to wr_en, wr_addr and wr_data. Also adds a combinational "busy_next" view in which the bit being cleared this cycle already reads 0. Decode can then consume load data one cycle earlier.
- Undefined: these ports are absent and busy is purely registered.

Decomposition:
- Package wb_pkg holds:
  - NREGS and XLEN constants
  - reg_addr_t (4-bit) and word_t (XLEN-bit) typedefs
  - the skid state enum {SKID_EMPTY, SKID_FULL}
- One sub-module, wb_scoreboard: busy vector, set/clear rules, err_double.
- stage_writeback keeps the arbitration, skid buffer and output register.

Test Plan:
- ex_valid, addr 3, data 0x12345678, no load → wr_en in cycle N+1 with addr 3 / 0x12345678; ex_ready stays 1.
- ld_issue addr 5, then 4 cycles later ld_resp addr 5, data 0xDEADBEEF → busy[5]=1 from issue+1 until the cycle wr_en shows addr 5 / 0xDEADBEEF, then busy[5]=0.
- Same-cycle ex (addr 2, 0x1) and ld_resp (addr 7, 0x2):
  - wr writes addr 7 then addr 2 in consecutive cycles.
  - ex_ready=0 for exactly one cycle.
- Back-to-back load responses for 3 cycles with skid full → ex_ready held 0, skid data unchanged, writes on the first free cycle.
- ld_issue addr 4 twice with no response → err_double=1 and remains set. Issue with addr 0 → busy unchanged. ex write to addr 0 → no wr_en.
- Assert rst with skid full and busy=0x0030 → all outputs zero immediately (async), ex_ready=1 after release, no stale write emitted.
